// File: rtl/bnc_pkg.sv
// rtl/bnc_pkg.sv - shared state encoding, keyword characters and case folding for block_nest_checker
package bnc_pkg;

  typedef enum logic [3:0] {
    ST_IDLE  = 4'd0,
    ST_B     = 4'd1,
    ST_BE    = 4'd2,
    ST_BEG   = 4'd3,
    ST_BEGI  = 4'd4,
    ST_BGN_T = 4'd5,
    ST_E     = 4'd6,
    ST_EN    = 4'd7,
    ST_END_T = 4'd8,
    ST_OTHER = 4'd9
  } bnc_state_e;

  localparam logic [7:0] CH_SEP = 8'h20;
  localparam logic [7:0] CH_B   = 8'h62;
  localparam logic [7:0] CH_E   = 8'h65;
  localparam logic [7:0] CH_G   = 8'h67;
  localparam logic [7:0] CH_I   = 8'h69;
  localparam logic [7:0] CH_N   = 8'h6e;
  localparam logic [7:0] CH_D   = 8'h64;

  function automatic logic [7:0] to_lower(input logic [7:0] c);
    if (c >= 8'h41 && c <= 8'h5a) return c | 8'h20;
    return c;
  endfunction

endpackage

// File: rtl/bnc_word_fsm.sv
// rtl/bnc_word_fsm.sv - begin/end keyword matcher producing tentative, commit and revert strobes
module bnc_word_fsm
  import bnc_pkg::*;
#(
  parameter logic [7:0] SEP_CHAR = CH_SEP
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] i_char,
  input  logic       i_valid,
  output logic       o_inc_t,
  output logic       o_dec_t,
  output logic       o_commit,
  output logic       o_revert,
  output logic       o_tent_begin
);

  bnc_state_e r_state;
  bnc_state_e w_state_nxt;
  logic [7:0] w_ch;
  logic       w_sep;

  assign w_ch         = to_lower(i_char);
  assign w_sep        = (i_char == SEP_CHAR);
  assign o_tent_begin = (r_state == ST_BGN_T);

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    o_inc_t     = 1'b0;
    o_dec_t     = 1'b0;
    o_commit    = 1'b0;
    o_revert    = 1'b0;
    if (i_valid) begin
      // A separator always ends the current word, whatever the state.
      if (w_sep) begin
        w_state_nxt = ST_IDLE;
        o_commit    = (r_state == ST_BGN_T) || (r_state == ST_END_T);
      end else begin
        w_state_nxt = ST_OTHER;
        case (r_state)
          ST_IDLE: begin
            if (w_ch == CH_B)      w_state_nxt = ST_B;
            else if (w_ch == CH_E) w_state_nxt = ST_E;
          end
          ST_B:    if (w_ch == CH_E) w_state_nxt = ST_BE;
          ST_BE:   if (w_ch == CH_G) w_state_nxt = ST_BEG;
          ST_BEG:  if (w_ch == CH_I) w_state_nxt = ST_BEGI;
          ST_BEGI: begin
            if (w_ch == CH_N) begin
              w_state_nxt = ST_BGN_T;
              o_inc_t     = 1'b1;
            end
          end
          ST_E:    if (w_ch == CH_N) w_state_nxt = ST_EN;
          ST_EN: begin
            if (w_ch == CH_D) begin
              w_state_nxt = ST_END_T;
              o_dec_t     = 1'b1;
            end
          end
          ST_BGN_T, ST_END_T: o_revert = 1'b1;
          default: w_state_nxt = ST_OTHER;
        endcase
      end
    end
  end

endmodule

// File: rtl/block_nest_checker.sv
// rtl/block_nest_checker.sv - streaming begin/end nesting checker with depth and sticky errors
// Optional max_depth output when BNC_MAXDEPTH_EN is defined.
module block_nest_checker
  import bnc_pkg::*;
#(
  parameter int         DEPTH_W  = 4,
  parameter logic [7:0] SEP_CHAR = 8'h20
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [7:0]         in,
  input  logic               in_valid,
  output logic               result,
  output logic [DEPTH_W-1:0] depth,
  output logic               err_under,
`ifdef BNC_MAXDEPTH_EN
  output logic               err_over,
  output logic [DEPTH_W-1:0] max_depth
`else
  output logic               err_over
`endif
);

  localparam logic [DEPTH_W-1:0] MAX_D = '1;

  logic               w_inc_t, w_dec_t, w_commit, w_revert, w_tent_begin;
  logic [DEPTH_W-1:0] r_depth, w_depth_nxt;
  logic               r_applied, w_applied_nxt;
  logic               r_pend, w_pend_nxt;
  logic               r_eu, w_eu_nxt;
  logic               r_eo, w_eo_nxt;
  logic               r_result;

  bnc_word_fsm #(.SEP_CHAR(SEP_CHAR)) u_fsm (
    .clk          (clk),
    .reset        (reset),
    .i_char       (in),
    .i_valid      (in_valid),
    .o_inc_t      (w_inc_t),
    .o_dec_t      (w_dec_t),
    .o_commit     (w_commit),
    .o_revert     (w_revert),
    .o_tent_begin (w_tent_begin)
  );

  // r_applied remembers whether the tentative keyword really moved the depth,
  // so a revert after saturation or underflow leaves the counter alone.
  always_comb begin
    w_depth_nxt   = r_depth;
    w_applied_nxt = r_applied;
    w_pend_nxt    = r_pend;
    w_eu_nxt      = r_eu;
    w_eo_nxt      = r_eo;
    if (w_inc_t) begin
      if (r_depth == MAX_D) begin
        w_eo_nxt      = 1'b1;
        w_applied_nxt = 1'b0;
      end else begin
        w_depth_nxt   = r_depth + 1'b1;
        w_applied_nxt = 1'b1;
      end
    end
    if (w_dec_t) begin
      if (r_depth == '0) begin
        w_pend_nxt    = 1'b1;
        w_applied_nxt = 1'b0;
      end else begin
        w_depth_nxt   = r_depth - 1'b1;
        w_applied_nxt = 1'b1;
      end
    end
    if (w_revert) begin
      w_pend_nxt = 1'b0;
      if (r_applied) w_depth_nxt = w_tent_begin ? r_depth - 1'b1 : r_depth + 1'b1;
    end
    if (w_commit && !w_tent_begin && r_pend) begin
      w_eu_nxt   = 1'b1;
      w_pend_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_depth   <= '0;
      r_applied <= 1'b0;
      r_pend    <= 1'b0;
      r_eu      <= 1'b0;
      r_eo      <= 1'b0;
      r_result  <= 1'b1;
    end else begin
      r_depth   <= w_depth_nxt;
      r_applied <= w_applied_nxt;
      r_pend    <= w_pend_nxt;
      r_eu      <= w_eu_nxt;
      r_eo      <= w_eo_nxt;
      r_result  <= (w_depth_nxt == '0) & ~w_pend_nxt & ~w_eu_nxt & ~w_eo_nxt;
    end
  end

`ifdef BNC_MAXDEPTH_EN
  logic [DEPTH_W-1:0] r_max_depth;

  always_ff @(posedge clk) begin
    if (reset) r_max_depth <= '0;
    else if (w_commit && w_tent_begin && (r_depth > r_max_depth)) r_max_depth <= r_depth;
  end

  assign max_depth = r_max_depth;
`endif

  assign result    = r_result;
  assign depth     = r_depth;
  assign err_under = r_eu;
  assign err_over  = r_eo;

endmodule

// File: tb/tb_block_nest_checker.sv
// tb/tb_block_nest_checker.sv - directed self-checking bench for block_nest_checker (DEPTH_W 4 and 2)
module tb_block_nest_checker;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] in_ch;
  logic       in_valid;

  logic       res4, eu4, eo4;
  logic [3:0] dep4;
  logic       res2, eu2, eo2;
  logic [1:0] dep2;
`ifdef BNC_MAXDEPTH_EN
  logic [3:0] max4;
  logic [1:0] max2;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  block_nest_checker #(.DEPTH_W(4)) u_dut4 (
    .clk       (clk),
    .reset     (reset),
    .in        (in_ch),
    .in_valid  (in_valid),
    .result    (res4),
    .depth     (dep4),
    .err_under (eu4),
`ifdef BNC_MAXDEPTH_EN
    .err_over  (eo4),
    .max_depth (max4)
`else
    .err_over  (eo4)
`endif
  );

  block_nest_checker #(.DEPTH_W(2)) u_dut2 (
    .clk       (clk),
    .reset     (reset),
    .in        (in_ch),
    .in_valid  (in_valid),
    .result    (res2),
    .depth     (dep2),
    .err_under (eu2),
`ifdef BNC_MAXDEPTH_EN
    .err_over  (eo2),
    .max_depth (max2)
`else
    .err_over  (eo2)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send(input string s);
    for (int i = 0; i < s.len(); i++) begin
      in_ch    = s[i];
      in_valid = 1'b1;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    in_ch    = 8'h00;
    in_valid = 1'b0;
    do_reset();
    check("rst_result", res4, 1);
    check("rst_depth", dep4, 0);
    check("rst_eu", eu4, 0);
    check("rst_eo", eo4, 0);
`ifdef BNC_MAXDEPTH_EN
    check("rst_max", max4, 0);
`endif

    send("a BEgI");
    check("t1_depth_pre_n", dep4, 0);
    send("n");
    check("t1_depth_after_n", dep4, 1);
    check("t1_result_open", res4, 0);
    send(" End");
    check("t1_depth_after_d", dep4, 0);
    check("t1_result_after_d", res4, 1);
    send(" ");
    check("t1_result_end", res4, 1);
    check("t1_eu", eu4, 0);
    check("t1_eo", eo4, 0);

    do_reset();
    send("begin begin endc");
    check("t2_depth_endc", dep4, 2);
    send(" end ");
    check("t2_depth", dep4, 1);
    check("t2_result", res4, 0);
    check("t2_eu", eu4, 0);
`ifdef BNC_MAXDEPTH_EN
    check("t2_max", max4, 2);
`endif

    do_reset();
    send("en");
    check("t3_result_pre_d", res4, 1);
    send("d");
    check("t3_result_pend", res4, 0);
    check("t3_eu_pend", eu4, 0);
    send(" ");
    check("t3_eu", eu4, 1);
    send("begin end ");
    check("t3_result_sticky", res4, 0);
    check("t3_depth", dep4, 0);
    check("t3_eu_sticky", eu4, 1);

    do_reset();
    send("end");
    check("t4_result_pend", res4, 0);
    send("x");
    check("t4_result_back", res4, 1);
    send(" ");
    check("t4_eu", eu4, 0);
    check("t4_result", res4, 1);

    do_reset();
    send("begin begin begin begi");
    check("t5_depth3", dep2, 3);
    check("t5_eo_pre", eo2, 0);
    send("n");
    check("t5_depth_sat", dep2, 3);
    check("t5_eo", eo2, 1);
    check("t5_result", res2, 0);
    send(" ");
    check("t5_depth_commit", dep2, 3);
    check("t5_wide_depth", dep4, 4);
    check("t5_wide_eo", eo4, 0);
`ifdef BNC_MAXDEPTH_EN
    check("t5_max", max2, 3);
`endif
    send("beginx ");
    check("t5_eo_sticky", eo2, 1);
    check("t5_depth_revert", dep2, 3);

    do_reset();
    send("be");
    for (int i = 0; i < 3; i++) begin
      in_ch = 8'h6e;
      @(posedge clk);
      #1;
      check("t6_gap_depth", dep4, 0);
      check("t6_gap_result", res4, 1);
    end
    send("gin ");
    check("t6_depth", dep4, 1);

    send("beg");
    in_ch    = 8'h69;
    in_valid = 1'b1;
    reset    = 1'b1;
    @(posedge clk);
    #1;
    reset    = 1'b0;
    in_valid = 1'b0;
    check("t7_depth", dep4, 0);
    check("t7_result", res4, 1);
    check("t7_eu", eu4, 0);
    check("t7_eo", eo4, 0);
    send("n ");
    check("t7_idle_depth", dep4, 0);
    check("t7_idle_result", res4, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/block_nest_checker.md
Name: block_nest_checker

Overview:
- Streaming ASCII checker for begin/end nesting. Generalises the single-flag block checker: adds a parametrised depth counter, an input valid qualifier, a depth output, and sticky underflow/overflow error flags.
- Consumes one character per accepted cycle. Keywords are case-insensitive.
- Sits after the character-source front end in the text-processing path and feeds the status/LED logic.

Parameters:
- DEPTH_W, 4, width of the nesting-depth counter; the maximum legal depth is 2^DEPTH_W-1.
- SEP_CHAR, 8'h20, the word-separator character. It is the only separator; every other byte is a word character.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- in  in  8  ASCII character
- in_valid  in  1  character accepted on a rising clk edge when high
- result  out  1  high when the stream so far is balanced: depth 0, no pending underflow, no error
- depth  out  DEPTH_W  current nesting depth, including any tentative begin/end
- err_under  out  1  sticky; a confirmed "end" arrived at depth 0
- err_over  out  1  sticky; a "begin" arrived at maximum depth
- max_depth  out  DEPTH_W  only present with BNC_MAXDEPTH_EN

Behaviour:
- Reset values: result=1, depth=0, err_under=0, err_over=0, max_depth=0, FSM=IDLE. Reset takes priority over in_valid and aborts any partial word.
- All outputs are registered. They reflect every character accepted up to and including the previous edge (latency 1 cycle).
- When in_valid=0, all state holds.
- Letters are folded to lower case (A-Z to a-z) before matching. Any non-letter, non-separator byte is an ordinary word character.
- FSM states: IDLE, B, BE, BEG, BEGI, BGN_T (tentative begin), E, EN, END_T (tentative end), OTHER.
  - IDLE: separator stays in IDLE; 'b' goes to B; 'e' goes to E; anything else goes to OTHER.
  - Prefix states advance on the matching next letter. A non-matching word character goes to OTHER. A separator goes to IDLE.
  - 'n' in BEGI goes to BGN_T with depth+1 applied immediately.
  - 'd' in EN goes to END_T with depth-1 applied immediately.
  - BGN_T / END_T: a separator commits the count and goes to IDLE. Any word character reverts the count ("beginx", "endc" are not keywords) and goes to OTHER.
  - OTHER: a separator goes to IDLE; anything else stays in OTHER.
- Underflow at depth 0: entering END_T does not decrement; it sets the internal flag pend_under, which forces result=0. A following separator sets err_under (sticky). A following word character clears pend_under.
- Overflow at maximum depth: entering BGN_T does not increment (depth saturates) and sets err_over immediately. err_over is not reverted even if the begin is later rejected.
- Once either error flag is set, result=0 until reset. depth keeps tracking normally.
- result = (depth==0) & ~pend_under & ~err_under & ~err_over.

Optional Feature:
- Macro: BNC_MAXDEPTH_EN.
- Defined: the max_depth port exists and holds the maximum committed depth since reset. It updates when a BGN_T is committed by a separator. Tentative depth never updates it.
- Undefined: the port and its register are absent; all other behaviour is identical.

Decomposition:
- Package bnc_pkg holds:
  - the FSM state enum (4-bit encoding);
  - constants CH_SEP, CH_B, CH_E, CH_G, CH_I, CH_N, CH_D;
  - a to_lower function.
- Sub-module bnc_word_fsm: letter matching and the tentative/commit/revert strobes (inc_t, dec_t, commit, revert).
- The top level owns the depth counter, error flags, result, and max_depth.

Test Plan:
- "a BEgIn End" then " ": depth goes 0→1 after 'n', 1→0 after 'd'; result=1 at the end; no errors.
- "begin begin endc end " (DEPTH_W=4): depth=1 at the end ("endc" is reverted); result=0; err_under=0.
- "end " from reset: result=0 one cycle after 'd'; err_under=1 after ' '; a following "begin end " keeps result=0.
- "endx " from reset: result drops after 'd', returns to 1 after 'x'; err_under stays 0.
- DEPTH_W=2, "begin "×4: depth saturates at 3 and err_over=1 on the 4th 'n'; with BNC_MAXDEPTH_EN, max_depth=3.
- in_valid toggled low mid-word ("be", gap of 3 cycles, "gin "): outputs unchanged during the gap; depth=1. Reset asserted mid-"beg": all outputs at reset values the next cycle, FSM=IDLE.
